// File: rtl/d2e_pipe_reg_pkg.sv
// rtl/d2e_pipe_reg_pkg.sv - shared constants and helpers for the D->E pipeline register
// Contents: EXTOp encodings, NOP word, Tnew width/max, register-zero index,
//           and the writeback-match helper used by the operand refresh slots.
package d2e_pipe_reg_pkg;

    // Immediate extender operation, decoded in D; only its result crosses into E.
    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b01,
        EXT_LUI  = 2'b10
    } ext_op_e;

    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam int          DEF_TNEW_W    = 2;
    localparam int          DEF_TNEW_MAX  = (1 << DEF_TNEW_W) - 1;
    localparam logic [4:0]  REG_ZERO      = 5'd0;

    // A writeback hits a held operand only if it really writes, is not $zero,
    // and names the same register the E stage is holding.
    function automatic logic wb_hits(
        input logic       we,
        input logic [4:0] wb_addr,
        input logic [4:0] held_addr
    );
        return we && (wb_addr != REG_ZERO) && (wb_addr == held_addr);
    endfunction

endpackage

// File: rtl/d2e_pipe_reg_refresh_slot.sv
// rtl/d2e_pipe_reg_refresh_slot.sv - one E-stage operand slot (addr + data) with hold-time writeback refresh
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   hold                  E stage frozen; only a writeback refresh may change data
//   bubble                load zeros (ignored while hold)
//   d_addr, d_data        D-side operand index/value captured otherwise
//   w_we, w_addr, w_data  W-stage write port snooped during hold
//   e_addr, e_data        registered operand presented to E
module d2e_refresh_slot
    import d2e_pipe_reg_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hold,
    input  logic        bubble,
    input  logic [4:0]  d_addr,
    input  logic [31:0] d_data,
    input  logic        w_we,
    input  logic [4:0]  w_addr,
    input  logic [31:0] w_data,
    output logic [4:0]  e_addr,
    output logic [31:0] e_data
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_addr <= '0;
            e_data <= '0;
        end else if (hold) begin
            // A held instruction would otherwise miss a result retiring in W
            // while the md unit stalls it; a bubble holds addr 0 so never matches.
            if (wb_hits(w_we, w_addr, e_addr)) begin
                e_data <= w_data;
            end
        end else if (bubble) begin
            e_addr <= '0;
            e_data <= '0;
        end else begin
            e_addr <= d_addr;
            e_data <= d_data;
        end
    end

endmodule

// File: rtl/d2e_pipe_reg.sv
// rtl/d2e_pipe_reg.sv - D->E pipeline register of the 5-stage MIPS core
// Optional build macro: D2E_BUBBLE_CNT_EN adds the bubble_cnt output.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   d_stall, d_flush              insert a bubble into E
//   e_hold                        freeze E (md busy); highest priority
//   d_instr, d_pc                 D instruction and PC
//   d_rs_addr/_data, d_rt_addr/_data  operand indices and forwarded values
//   d_ext_out                     extended immediate from D
//   d_tnew                        cycles until result ready, from E entry
//   w_we, w_addr, w_data          W write port for hold-time operand refresh
//   e_*                           registered bundle presented to E
//   bubble_cnt                    bubble-insert edge count (macro only)
module d2e_pipe_reg
    import d2e_pipe_reg_pkg::*;
#(
    parameter int          TNEW_W    = DEF_TNEW_W,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_stall,
    input  logic              d_flush,
    input  logic              e_hold,
    input  logic [31:0]       d_instr,
    input  logic [31:0]       d_pc,
    input  logic [4:0]        d_rs_addr,
    input  logic [4:0]        d_rt_addr,
    input  logic [31:0]       d_rs_data,
    input  logic [31:0]       d_rt_data,
    input  logic [31:0]       d_ext_out,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              w_we,
    input  logic [4:0]        w_addr,
    input  logic [31:0]       w_data,
    output logic              e_valid,
    output logic [31:0]       e_instr,
    output logic [31:0]       e_pc,
    output logic [4:0]        e_rs_addr,
    output logic [4:0]        e_rt_addr,
    output logic [31:0]       e_rs_data,
    output logic [31:0]       e_rt_data,
    output logic [31:0]       e_imm,
    output logic [TNEW_W-1:0] e_tnew
`ifdef D2E_BUBBLE_CNT_EN
    ,
    output logic [31:0]       bubble_cnt
`endif
);

    // Stall and flush collapse into one bubble; hold overrides both.
    logic bubble;
    assign bubble = d_stall | d_flush;

    d2e_refresh_slot u_rs_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (e_hold),
        .bubble  (bubble),
        .d_addr  (d_rs_addr),
        .d_data  (d_rs_data),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .e_addr  (e_rs_addr),
        .e_data  (e_rs_data)
    );

    d2e_refresh_slot u_rt_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (e_hold),
        .bubble  (bubble),
        .d_addr  (d_rt_addr),
        .d_data  (d_rt_data),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .e_addr  (e_rt_addr),
        .e_data  (e_rt_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_valid <= 1'b0;
            e_instr <= NOP_INSTR;
            e_pc    <= '0;
            e_imm   <= '0;
            e_tnew  <= '0;
        end else if (e_hold) begin
            // The held instruction keeps ageing so the hazard unit sees its
            // result approach readiness; saturate at 0.
            if (e_tnew != '0) begin
                e_tnew <= e_tnew - TNEW_W'(1);
            end
        end else if (bubble) begin
            e_valid <= 1'b0;
            e_instr <= NOP_INSTR;
            e_pc    <= '0;
            e_imm   <= '0;
            e_tnew  <= '0;
        end else begin
            e_valid <= 1'b1;
            e_instr <= d_instr;
            e_pc    <= d_pc;
            e_imm   <= d_ext_out;
            e_tnew  <= d_tnew;
        end
    end

`ifdef D2E_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt <= '0;
        end else if (!e_hold && bubble) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d2e_pipe_reg.sv
// tb/tb_d2e_pipe_reg.sv - self-checking bench for d2e_pipe_reg
module tb_d2e_pipe_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        d_stall, d_flush, e_hold;
    logic [31:0] d_instr, d_pc, d_rs_data, d_rt_data, d_ext_out;
    logic [4:0]  d_rs_addr, d_rt_addr;
    logic [1:0]  d_tnew;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_rs_data, e_rt_data, e_imm;
    logic [4:0]  e_rs_addr, e_rt_addr;
    logic [1:0]  e_tnew;
`ifdef D2E_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d2e_pipe_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_stall   (d_stall),
        .d_flush   (d_flush),
        .e_hold    (e_hold),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .d_rs_addr (d_rs_addr),
        .d_rt_addr (d_rt_addr),
        .d_rs_data (d_rs_data),
        .d_rt_data (d_rt_data),
        .d_ext_out (d_ext_out),
        .d_tnew    (d_tnew),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .e_valid   (e_valid),
        .e_instr   (e_instr),
        .e_pc      (e_pc),
        .e_rs_addr (e_rs_addr),
        .e_rt_addr (e_rt_addr),
        .e_rs_data (e_rs_data),
        .e_rt_data (e_rt_data),
        .e_imm     (e_imm),
        .e_tnew    (e_tnew)
`ifdef D2E_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    // Reference model: the E-stage bundle as a record, updated from the rules
    // "hold ages Tnew and snoops W, else bubble clears, else copy D".
    typedef struct {
        bit          valid;
        logic [31:0] instr, pc, rs_data, rt_data, imm;
        logic [4:0]  rs_addr, rt_addr;
        int          tnew;
    } e_bundle_t;

    e_bundle_t m;
    longint    m_bubbles;

    function automatic e_bundle_t empty_bundle();
        e_bundle_t b;
        b.valid = 0; b.instr = 32'h0; b.pc = 0; b.rs_data = 0; b.rt_data = 0;
        b.imm = 0; b.rs_addr = 0; b.rt_addr = 0; b.tnew = 0;
        return b;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m = empty_bundle();
            m_bubbles = 0;
        end else if (e_hold) begin
            m.tnew = (m.tnew > 0) ? m.tnew - 1 : 0;
            if (w_we && w_addr != 0) begin
                if (w_addr == m.rs_addr) m.rs_data = w_data;
                if (w_addr == m.rt_addr) m.rt_data = w_data;
            end
        end else if (d_stall || d_flush) begin
            m = empty_bundle();
            m_bubbles = (m_bubbles + 1) % 64'h1_0000_0000;
        end else begin
            m.valid = 1; m.instr = d_instr; m.pc = d_pc; m.imm = d_ext_out;
            m.rs_addr = d_rs_addr; m.rt_addr = d_rt_addr;
            m.rs_data = d_rs_data; m.rt_data = d_rt_data; m.tnew = int'(d_tnew);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("m_valid",   32'(e_valid),   32'(m.valid));
        check("m_instr",   e_instr,        m.instr);
        check("m_pc",      e_pc,           m.pc);
        check("m_imm",     e_imm,          m.imm);
        check("m_rs_addr", 32'(e_rs_addr), 32'(m.rs_addr));
        check("m_rt_addr", 32'(e_rt_addr), 32'(m.rt_addr));
        check("m_rs_data", e_rs_data,      m.rs_data);
        check("m_rt_data", e_rt_data,      m.rt_data);
        check("m_tnew",    32'(e_tnew),    32'(m.tnew));
`ifdef D2E_BUBBLE_CNT_EN
        check("m_bubble_cnt", bubble_cnt, 32'(m_bubbles));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic [31:0] ext, input logic [1:0] tnew);
        d_instr = instr; d_pc = pc; d_rs_addr = rs; d_rt_addr = rt;
        d_rs_data = rsd; d_rt_data = rtd; d_ext_out = ext; d_tnew = tnew;
    endtask

    logic [31:0] held_instr;
`ifdef D2E_BUBBLE_CNT_EN
    logic [31:0] cnt0;
`endif

    initial begin
        reset_n = 0; d_stall = 0; d_flush = 0; e_hold = 0;
        w_we = 0; w_addr = 0; w_data = 0;
        drive_d(32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0);
        #12;
        check("rst_valid", 32'(e_valid), 32'h0);
        check("rst_instr", e_instr, 32'h0);
        reset_n = 1;

        // Capture of a LUI bundle
        drive_d(32'h3C01_1234, 32'h0000_3000, 5'd0, 5'd1, 32'h0, 32'h0, 32'h1234_0000, 2'd1);
        step();
        check("cap_imm",   e_imm, 32'h1234_0000);
        check("cap_pc",    e_pc, 32'h0000_3000);
        check("cap_tnew",  32'(e_tnew), 32'd1);
        check("cap_valid", 32'(e_valid), 32'd1);
        check("cap_instr", e_instr, 32'h3C01_1234);

        // Asynchronous reset mid-cycle while valid
        #2 reset_n = 0;
        #1;
        check("arst_valid", 32'(e_valid), 32'h0);
        check("arst_instr", e_instr, 32'h0);
        check("arst_tnew",  32'(e_tnew), 32'h0);
        check("arst_imm",   e_imm, 32'h0);
        #3 reset_n = 1;

        // Capture then bubble via stall
        drive_d(32'h0022_1820, 32'h0000_3004, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0000_1820, 2'd1);
        step();
        check("cap2_rs_data", e_rs_data, 32'h11);
`ifdef D2E_BUBBLE_CNT_EN
        cnt0 = bubble_cnt;
`endif
        d_stall = 1;
        step();
        check("stall_valid", 32'(e_valid), 32'h0);
        check("stall_instr", e_instr, 32'h0);
        check("stall_rs_addr", 32'(e_rs_addr), 32'h0);
`ifdef D2E_BUBBLE_CNT_EN
        check("cnt_stall", bubble_cnt, cnt0 + 32'd1);
`endif
        d_flush = 1;
        step();
        check("both_valid", 32'(e_valid), 32'h0);
`ifdef D2E_BUBBLE_CNT_EN
        check("cnt_both", bubble_cnt, cnt0 + 32'd2);
`endif
        d_stall = 0; d_flush = 0;

        // Hold with Tnew countdown; flush ignored while held
        drive_d(32'h8CA5_0004, 32'h0000_3010, 5'd5, 5'd5, 32'h55, 32'h66, 32'h0000_0004, 2'd2);
        step();
        held_instr = 32'h8CA5_0004;
        e_hold = 1; d_flush = 1;
        drive_d(32'hFFFF_FFFF, 32'h0000_4000, 5'd9, 5'd9, 32'h99, 32'h99, 32'h9, 2'd3);
        step();
        check("hold_tnew1", 32'(e_tnew), 32'd1);
        check("hold_instr1", e_instr, held_instr);
        step();
        check("hold_tnew0", 32'(e_tnew), 32'd0);
`ifdef D2E_BUBBLE_CNT_EN
        check("cnt_hold", bubble_cnt, cnt0 + 32'd2);
`endif
        step();
        check("hold_tnew_sat", 32'(e_tnew), 32'd0);
        check("hold_instr3", e_instr, held_instr);
        check("hold_valid", 32'(e_valid), 32'd1);
        d_flush = 0;

        // Refresh during hold: both slots hit
        w_we = 1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF;
        step();
        check("ref_rs", e_rs_data, 32'hDEAD_BEEF);
        check("ref_rt", e_rt_data, 32'hDEAD_BEEF);
        w_addr = 5'd0; w_data = 32'h1111_1111;
        step();
        check("ref_zero_rs", e_rs_data, 32'hDEAD_BEEF);
        check("ref_zero_rt", e_rt_data, 32'hDEAD_BEEF);
        w_we = 0; w_addr = 5'd5; w_data = 32'h2222_2222;
        step();
        check("ref_nowe_rs", e_rs_data, 32'hDEAD_BEEF);

        // Release: new bundle captured, Tnew reloaded
        e_hold = 0;
        drive_d(32'h0107_4820, 32'h0000_3014, 5'd7, 5'd9, 32'h77, 32'h99, 32'h0000_4820, 2'd3);
        step();
        check("rel_tnew", 32'(e_tnew), 32'd3);
        check("rel_instr", e_instr, 32'h0107_4820);
        check("rel_valid", 32'(e_valid), 32'd1);

        // Independent refresh: only rt matches
        e_hold = 1; w_we = 1; w_addr = 5'd9; w_data = 32'hCAFE_0009;
        step();
        check("ind_rs", e_rs_data, 32'h77);
        check("ind_rt", e_rt_data, 32'hCAFE_0009);

        // Refresh is ignored outside hold: capture wins
        e_hold = 0; w_addr = 5'd3; w_data = 32'hBAD0_0003;
        drive_d(32'h0003_1821, 32'h0000_3018, 5'd3, 5'd3, 32'h33, 32'h34, 32'h0, 2'd0);
        step();
        check("nohold_rs", e_rs_data, 32'h33);
        check("nohold_rt", e_rt_data, 32'h34);
        w_we = 0;

        // A short mixed run for the model comparator
        for (int i = 0; i < 12; i++) begin
            e_hold  = (i % 5 == 3);
            d_stall = (i % 4 == 1);
            d_flush = (i % 6 == 2);
            w_we = (i % 2 == 0); w_addr = 5'(i % 4); w_data = 32'hA000_0000 + 32'(i);
            drive_d(32'h1000_0000 + 32'(i), 32'h0000_5000 + 32'(4 * i), 5'(i % 4), 5'((i + 1) % 4),
                    32'h100 + 32'(i), 32'h200 + 32'(i), 32'hFFFF_0000 | 32'(i), 2'(i));
            step();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
